// File: rtl/max_pair_feeder.sv
//==============================================================================
// Module      : max_pair_feeder
// Description : Collects two operands from a valid/ready stream, lets an
//               external comparator judge them for one full cycle, and holds
//               the larger one until the consumer accepts it.
//               Optional MAX_PAIR_COUNT_EN adds a saturating 16-bit
//               completed-pair counter output (pair_count).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module max_pair_feeder #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] num1,
    output logic [DATA_W-1:0] num2,
    input  logic              cmp_gt,
    output logic [DATA_W-1:0] out_max,
    output logic              out_first,
    output logic              out_valid,
    input  logic              out_ready
`ifdef MAX_PAIR_COUNT_EN
    ,
    output logic [15:0]       pair_count
`endif
);

    localparam logic [1:0] c_LOAD_A = 2'd0;
    localparam logic [1:0] c_LOAD_B = 2'd1;
    localparam logic [1:0] c_CMP    = 2'd2;
    localparam logic [1:0] c_HOLD   = 2'd3;

    logic [1:0]        r_state;
    logic [1:0]        w_next_state;
    logic [DATA_W-1:0] r_num1;
    logic [DATA_W-1:0] r_num2;
    logic [DATA_W-1:0] r_out_max;
    logic              r_out_first;
    logic              r_out_valid;
    logic              w_in_xfer;
    logic              w_out_xfer;

    // Gated by rst so upstream never sees ready during an asserted reset.
    assign in_ready   = ~rst & ((r_state == c_LOAD_A) | (r_state == c_LOAD_B));
    assign w_in_xfer  = in_valid & in_ready;
    assign w_out_xfer = r_out_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_LOAD_A;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_LOAD_A: if (w_in_xfer)  w_next_state = c_LOAD_B;
            c_LOAD_B: if (w_in_xfer)  w_next_state = c_CMP;
            c_CMP:                    w_next_state = c_HOLD;
            c_HOLD:   if (w_out_xfer) w_next_state = c_LOAD_A;
            default:                  w_next_state = c_LOAD_A;
        endcase
    end

    // Operands only move on their own capture edge, so they stay stable
    // through CMP and HOLD for the comparator and the consumer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_num1      <= '0;
            r_num2      <= '0;
            r_out_max   <= '0;
            r_out_first <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            if ((r_state == c_LOAD_A) && w_in_xfer) begin
                r_num1 <= in_data;
            end
            if ((r_state == c_LOAD_B) && w_in_xfer) begin
                r_num2 <= in_data;
            end
            if (r_state == c_CMP) begin
                r_out_first <= cmp_gt;
                r_out_max   <= cmp_gt ? r_num1 : r_num2;
                r_out_valid <= 1'b1;
            end
            if (w_out_xfer) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign num1      = r_num1;
    assign num2      = r_num2;
    assign out_max   = r_out_max;
    assign out_first = r_out_first;
    assign out_valid = r_out_valid;

`ifdef MAX_PAIR_COUNT_EN
    logic [15:0] r_pair_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pair_count <= '0;
        end else if (w_out_xfer && (r_pair_count != 16'hFFFF)) begin
            r_pair_count <= r_pair_count + 16'd1;
        end
    end

    assign pair_count = r_pair_count;
`endif

endmodule

`default_nettype wire
